// File: rtl/rcui2c_pkg.sv
// Shared types and constants for the RCU board-controller I2C master.
package rcui2c_pkg;

  typedef enum logic [6:0] {
    IDLE    = 7'b000_0001,
    START   = 7'b000_0010,
    TX_BYTE = 7'b000_0100,
    RX_BYTE = 7'b000_1000,
    ACK     = 7'b001_0000,
    STOP    = 7'b010_0000,
    ILLEGAL = 7'b100_0000
  } state_e;

  // Slot numbers match the TRU slave's slave_ack_flag so traces line up.
  localparam logic [5:0] SLOT_ADDR_ACK = 6'h08;
  localparam logic [5:0] SLOT_REG_ACK  = 6'h11;
  localparam logic [5:0] SLOT_HI_ACK   = 6'h1A;
  localparam logic [5:0] SLOT_LO_ACK   = 6'h23;
  localparam logic [5:0] SLOT_STOP     = 6'h24;

  function automatic logic [7:0] frame_byte(
    input logic [1:0]  idx,
    input logic        bcast,
    input logic [4:0]  card,
    input logic        rnw,
    input logic [7:0]  reg_addr,
    input logic [15:0] wdata
  );
    logic [7:0] b;
    case (idx)
      2'd0:    b = {1'b0, bcast, card, rnw};
      2'd1:    b = reg_addr;
      2'd2:    b = wdata[15:8];
      default: b = wdata[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rcui2c_qtick.sv
// Quarter-bit timebase: q pulses every QTR_DIV cycles, p counts quarters 0..3.
module rcui2c_qtick #(
  parameter int unsigned QTR_DIV = 100
) (
  input  logic       clk_40m,
  input  logic       reset,
  input  logic       restart_i,
  input  logic       en_i,
  output logic       q_o,
  output logic [1:0] p_o
);

  localparam logic [9:0] CNT_MAX = 10'(QTR_DIV - 1);

  logic [9:0] cnt_q;
  logic [1:0] p_q;

  always_ff @(posedge clk_40m or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      p_q   <= '0;
    end else if (restart_i) begin
      cnt_q <= '0;
      p_q   <= '0;
    end else if (en_i) begin
      if (cnt_q == CNT_MAX) begin
        cnt_q <= '0;
        p_q   <= p_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + 10'd1;
      end
    end
  end

  assign q_o = en_i && (cnt_q == CNT_MAX);
  assign p_o = p_q;

endmodule

// File: rtl/rcui2c_master.sv
// I2C-style master issuing one 4-byte frame per command to the TRU/FEE board controller.
// Every FSM action happens on a quarter tick and sets the lines for the quarter that follows.
module rcui2c_master
  import rcui2c_pkg::*;
#(
  parameter int unsigned QTR_DIV = 100
) (
  input  logic        clk_40m,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic        cmd_rnw,
  input  logic        cmd_bcast,
  input  logic [4:0]  cmd_card_addr,
  input  logic [7:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wr_data,
  output logic        busy,
  output logic        done,
  output logic        ack_error,
  output logic [15:0] rd_data,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i
);

  state_e      state_q;
  logic [5:0]  slot_q;
  logic [2:0]  bit_q;
  logic [1:0]  byte_q;
  logic [7:0]  tx_q;
  logic [15:0] rx_q;
  logic        rnw_q, bcast_q;
  logic [4:0]  card_q;
  logic [7:0]  reg_q;
  logic [15:0] wdata_q;
  logic        scl_oe_q, sda_oe_q, busy_q, done_q, ack_err_q;
  logic [15:0] rd_data_q;
  logic        sda_s1_q, sda_s2_q;

  logic        accept_d, tick_en_d, q_tick;
  logic [1:0]  phase;
  logic [1:0]  byte_d;
  logic [7:0]  addr_byte_d, next_byte_d;
  logic        next_tx_d, slave_ack_d, last_ack_d;

  // A command landing in the same cycle as done is dropped, not queued.
  assign accept_d    = (state_q == IDLE) && cmd_start && !done_q;
  assign tick_en_d   = (state_q != IDLE) && (state_q != ILLEGAL);
  assign byte_d      = byte_q + 2'd1;
  assign addr_byte_d = {1'b0, bcast_q, card_q, rnw_q};
  assign next_byte_d = frame_byte(byte_d, bcast_q, card_q, rnw_q, reg_q, wdata_q);
  assign next_tx_d   = !(rnw_q && byte_d[1]);
  assign slave_ack_d = !rnw_q || (slot_q == SLOT_ADDR_ACK) || (slot_q == SLOT_REG_ACK);
  assign last_ack_d  = (slot_q == SLOT_LO_ACK);

  rcui2c_qtick #(.QTR_DIV(QTR_DIV)) u_qtick (
    .clk_40m  (clk_40m),
    .reset    (reset),
    .restart_i(accept_d),
    .en_i     (tick_en_d),
    .q_o      (q_tick),
    .p_o      (phase)
  );

  always_ff @(posedge clk_40m or negedge reset) begin
    if (!reset) begin
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
    end
  end

  always_ff @(posedge clk_40m or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rnw_q     <= 1'b0;
      bcast_q   <= 1'b0;
      card_q    <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept_d) begin
            rnw_q     <= cmd_rnw;
            bcast_q   <= cmd_bcast;
            card_q    <= cmd_card_addr;
            reg_q     <= cmd_reg_addr;
            wdata_q   <= cmd_wr_data;
            busy_q    <= 1'b1;
            ack_err_q <= 1'b0;
            slot_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            state_q   <= (cmd_bcast && cmd_rnw) ? ILLEGAL : START;
          end
        end

        ILLEGAL: begin
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          ack_err_q <= 1'b1;
          state_q   <= IDLE;
        end

        START: begin
          if (q_tick) begin
            case (phase)
              2'd0: sda_oe_q <= 1'b1;
              2'd2: scl_oe_q <= 1'b1;
              2'd3: begin
                tx_q     <= addr_byte_d;
                sda_oe_q <= ~addr_byte_d[7];
                state_q  <= TX_BYTE;
              end
              default: ;
            endcase
          end
        end

        TX_BYTE, RX_BYTE: begin
          if (q_tick) begin
            case (phase)
              2'd0: scl_oe_q <= 1'b0;
              2'd2: begin
                scl_oe_q <= 1'b1;
                if (state_q == RX_BYTE) rx_q <= {rx_q[14:0], sda_s2_q};
              end
              2'd3: begin
                slot_q <= slot_q + 6'd1;
                if (bit_q == 3'd7) begin
                  // Master drives ACK only after the read high byte; the low byte gets NACK.
                  state_q  <= ACK;
                  sda_oe_q <= rnw_q && ((slot_q + 6'd1) == SLOT_HI_ACK);
                end else begin
                  bit_q    <= bit_q + 3'd1;
                  tx_q     <= {tx_q[6:0], 1'b0};
                  sda_oe_q <= (state_q == TX_BYTE) ? ~tx_q[6] : 1'b0;
                end
              end
              default: ;
            endcase
          end
        end

        ACK: begin
          if (q_tick) begin
            case (phase)
              2'd0: scl_oe_q <= 1'b0;
              2'd2: begin
                scl_oe_q <= 1'b1;
                if (slave_ack_d && sda_s2_q) ack_err_q <= 1'b1;
              end
              2'd3: begin
                if (ack_err_q || last_ack_d) begin
                  state_q  <= STOP;
                  slot_q   <= SLOT_STOP;
                  sda_oe_q <= 1'b1;
                end else begin
                  slot_q <= slot_q + 6'd1;
                  byte_q <= byte_d;
                  bit_q  <= '0;
                  tx_q   <= next_byte_d;
                  if (next_tx_d) begin
                    state_q  <= TX_BYTE;
                    sda_oe_q <= ~next_byte_d[7];
                  end else begin
                    state_q  <= RX_BYTE;
                    sda_oe_q <= 1'b0;
                  end
                end
              end
              default: ;
            endcase
          end
        end

        STOP: begin
          if (q_tick) begin
            case (phase)
              2'd0: scl_oe_q <= 1'b0;
              2'd1: sda_oe_q <= 1'b0;
              2'd3: begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                if (rnw_q && !ack_err_q) rd_data_q <= rx_q;
              end
              default: ;
            endcase
          end
        end

        default: begin
          state_q  <= IDLE;
          scl_oe_q <= 1'b0;
          sda_oe_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_error = ack_err_q;
  assign rd_data   = rd_data_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_rcui2c_master.sv
// Bench for rcui2c_master: open-drain bus with a behavioural TRU slave and a byte scoreboard.
module tb_rcui2c_master;

  localparam int unsigned QTR = 10;
  localparam int FRAME_CYC = 152 * QTR;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        cmdStart = 1'b0, cmdRnw = 1'b0, cmdBcast = 1'b0;
  logic [4:0]  cmdCard = '0;
  logic [7:0]  cmdReg = '0;
  logic [15:0] cmdWdata = '0;
  logic        busy, done, ackErr, sclOe, sdaOe;
  logic [15:0] rdData;
  logic        slavePull = 1'b0;

  wire sclLine = ~sclOe;
  wire sdaLine = ~(sdaOe | slavePull);

  int nVectors = 0;
  int nMiscompares = 0;
  int cycle = 0;
  int startCycle = 0;
  logic [31:0] expQ[$];

  int          sSlot = -1;
  bit          sActive = 1'b0;
  bit          sRead = 1'b0;
  logic [7:0]  sShift = '0;
  logic [15:0] sRdData = '0;
  int          nackSlot = -1;
  int          sclRises = 0;
  int          stopSeen = 0;
  logic        mAckBit = 1'b1, mNackBit = 1'b0;
  bit          monBus = 1'b0;
  int          busDriven = 0;

  rcui2c_master #(.QTR_DIV(QTR)) dut (
    .clk_40m      (clk),
    .reset        (rstN),
    .cmd_start    (cmdStart),
    .cmd_rnw      (cmdRnw),
    .cmd_bcast    (cmdBcast),
    .cmd_card_addr(cmdCard),
    .cmd_reg_addr (cmdReg),
    .cmd_wr_data  (cmdWdata),
    .busy         (busy),
    .done         (done),
    .ack_error    (ackErr),
    .rd_data      (rdData),
    .scl_oe       (sclOe),
    .sda_oe       (sdaOe),
    .sda_i        (sdaLine)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle++;
    if (monBus && (sclOe || sdaOe)) busDriven++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic captureByte(input logic [7:0] b);
    logic [31:0] e;
    e = 32'hFFFF_FFFF;
    if (expQ.size() > 0) e = expQ.pop_front();
    checkOutput("busByte", {24'h0, b}, e);
  endtask

  task automatic slaveReset();
    sActive   = 1'b0;
    sSlot     = -1;
    slavePull = 1'b0;
  endtask

  // Slave sees START/STOP as SDA edges while SCL is high.
  always @(negedge sdaLine) if (sclLine === 1'b1) begin
    sActive   = 1'b1;
    sSlot     = -1;
    sRead     = 1'b0;
    slavePull = 1'b0;
  end

  always @(posedge sdaLine) if (sclLine === 1'b1 && sActive) begin
    sActive   = 1'b0;
    slavePull = 1'b0;
    stopSeen++;
  end

  always @(posedge sclLine) begin : slaveSample
    int bitIdx, byteIdx;
    sclRises++;
    if (sActive && sSlot >= 0 && sSlot < 36) begin
      bitIdx  = sSlot % 9;
      byteIdx = sSlot / 9;
      if (bitIdx < 8) begin
        if (!(sRead && byteIdx >= 2)) begin
          sShift = {sShift[6:0], sdaLine};
          if (bitIdx == 7) begin
            if (byteIdx == 0) sRead = sdaLine;
            captureByte(sShift);
          end
        end
      end else if (sRead && byteIdx == 2) begin
        mAckBit = sdaLine;
      end else if (sRead && byteIdx == 3) begin
        mNackBit = sdaLine;
      end
    end
  end

  // Slave updates SDA only while SCL is low, right after the falling edge.
  always @(negedge sclLine) if (sActive) begin : slaveDrive
    int bitIdx, byteIdx;
    sSlot++;
    slavePull = 1'b0;
    bitIdx  = sSlot % 9;
    byteIdx = sSlot / 9;
    if (byteIdx < 4) begin
      if (bitIdx == 8) begin
        if (!(sRead && byteIdx >= 2)) slavePull = (sSlot != nackSlot);
      end else if (sRead && byteIdx >= 2) begin
        slavePull = ~sRdData[((byteIdx == 2) ? 15 : 7) - bitIdx];
      end
    end
  end

  task automatic applyStimulus(input logic rnw, input logic bcast, input logic [4:0] card,
                               input logic [7:0] regA, input logic [15:0] wdata, input int nExp);
    logic [7:0] bytes [4];
    bytes[0] = {1'b0, bcast, card, rnw};
    bytes[1] = regA;
    bytes[2] = wdata[15:8];
    bytes[3] = wdata[7:0];
    for (int i = 0; i < nExp; i++) expQ.push_back({24'h0, bytes[i]});
    @(negedge clk);
    cmdRnw     = rnw;
    cmdBcast   = bcast;
    cmdCard    = card;
    cmdReg     = regA;
    cmdWdata   = wdata;
    cmdStart   = 1'b1;
    startCycle = cycle;
    @(negedge clk);
    cmdStart = 1'b0;
  endtask

  task automatic waitDone(input string tag, output int cycles);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 4 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {31'b0, done}, 32'd1);
    cycles = cycle - startCycle;
  endtask

  function automatic logic [31:0] frameLen(input int cycles);
    return (cycles >= FRAME_CYC - 8 && cycles <= FRAME_CYC + 8) ? FRAME_CYC : cycles;
  endfunction

  initial begin
    int cyc, r0, s0, n;

    repeat (3) @(negedge clk);
    checkOutput("resetState", {11'b0, busy, done, ackErr, sclOe, sdaOe, rdData}, 32'h0);
    rstN = 1'b1;
    slaveReset();
    repeat (2) @(negedge clk);

    $display("[TB] write card 0x0A reg 0x3C data 0xBEEF");
    r0 = sclRises;
    applyStimulus(1'b0, 1'b0, 5'h0A, 8'h3C, 16'hBEEF, 4);
    checkOutput("wrBusy", {31'b0, busy}, 32'd1);
    waitDone("wrDone", cyc);
    checkOutput("wrCycles", frameLen(cyc), FRAME_CYC);
    checkOutput("wrFlags", {30'b0, busy, ackErr}, 32'd0);
    checkOutput("wrSclRises", sclRises - r0, 32'd37);
    checkOutput("wrBytesLeft", expQ.size(), 32'd0);
    cmdCard  = 5'h01;
    cmdStart = 1'b1;
    @(negedge clk);
    cmdStart = 1'b0;
    @(negedge clk);
    checkOutput("startOnDoneIgnored", {30'b0, busy, sclOe}, 32'd0);

    $display("[TB] read card 0x03 reg 0x10");
    sRdData  = 16'h1234;
    mAckBit  = 1'b1;
    mNackBit = 1'b0;
    applyStimulus(1'b1, 1'b0, 5'h03, 8'h10, 16'h0000, 2);
    waitDone("rdDone", cyc);
    checkOutput("rdCycles", frameLen(cyc), FRAME_CYC);
    checkOutput("rdData", {16'h0, rdData}, 32'h1234);
    checkOutput("rdAckErr", {31'b0, ackErr}, 32'd0);
    checkOutput("rdMasterAckNack", {30'b0, mAckBit, mNackBit}, 32'b01);
    checkOutput("rdBytesLeft", expQ.size(), 32'd0);

    $display("[TB] write with slave NACK on register byte");
    nackSlot = 17;
    r0 = sclRises;
    s0 = stopSeen;
    applyStimulus(1'b0, 1'b0, 5'h05, 8'h22, 16'hAAAA, 2);
    waitDone("nackDone", cyc);
    checkOutput("nackAckErr", {31'b0, ackErr}, 32'd1);
    checkOutput("nackSclRises", sclRises - r0, 32'd19);
    checkOutput("nackStop", stopSeen - s0, 32'd1);
    checkOutput("nackBytesLeft", expQ.size(), 32'd0);
    checkOutput("nackRdDataHeld", {16'h0, rdData}, 32'h1234);
    nackSlot = -1;
    repeat (3) @(negedge clk);
    checkOutput("nackLinesReleased", {30'b0, sclOe, sdaOe}, 32'd0);

    $display("[TB] broadcast write");
    applyStimulus(1'b0, 1'b1, 5'h00, 8'h01, 16'h0055, 4);
    checkOutput("ackErrCleared", {31'b0, ackErr}, 32'd0);
    waitDone("bcDone", cyc);
    checkOutput("bcAckErr", {31'b0, ackErr}, 32'd0);
    checkOutput("bcBytesLeft", expQ.size(), 32'd0);

    $display("[TB] broadcast read is illegal");
    r0 = sclRises;
    busDriven = 0;
    monBus = 1'b1;
    applyStimulus(1'b1, 1'b1, 5'h00, 8'h44, 16'h0000, 0);
    checkOutput("illCycle1", {29'b0, busy, done, ackErr}, 32'b100);
    @(negedge clk);
    checkOutput("illCycle2", {29'b0, busy, done, ackErr}, 32'b011);
    repeat (10) @(negedge clk);
    monBus = 1'b0;
    checkOutput("illBusDriven", busDriven, 32'd0);
    checkOutput("illSclRises", sclRises - r0, 32'd0);

    $display("[TB] reset during data hi byte");
    applyStimulus(1'b0, 1'b0, 5'h0A, 8'h3C, 16'hBEEF, 4);
    n = 0;
    while (sSlot != 20 && n < 4 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachedByte2", sSlot, 32'd20);
    rstN = 1'b0;
    #1;
    checkOutput("midResetRelease", {29'b0, busy, sclOe, sdaOe}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    slaveReset();
    expQ.delete();
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 5'h11, 8'hA5, 16'h1357, 4);
    waitDone("postResetDone", cyc);
    checkOutput("postResetCycles", frameLen(cyc), FRAME_CYC);
    checkOutput("postResetAckErr", {31'b0, ackErr}, 32'd0);
    checkOutput("postResetBytesLeft", expQ.size(), 32'd0);

    $display("[TB] cmd_start while busy");
    sRdData = 16'h5678;
    applyStimulus(1'b1, 1'b0, 5'h07, 8'h20, 16'h0000, 2);
    repeat (200) @(negedge clk);
    cmdRnw   = 1'b0;
    cmdBcast = 1'b1;
    cmdCard  = 5'h1F;
    cmdReg   = 8'hFF;
    cmdWdata = 16'hFFFF;
    cmdStart = 1'b1;
    @(negedge clk);
    cmdStart = 1'b0;
    checkOutput("busyPulseRdData", {16'h0, rdData}, 32'h0000);
    checkOutput("busyPulseBusy", {31'b0, busy}, 32'd1);
    waitDone("busyPulseDone", cyc);
    checkOutput("busyPulseCycles", frameLen(cyc), FRAME_CYC);
    checkOutput("busyPulseRd", {16'h0, rdData}, 32'h5678);
    checkOutput("busyPulseAckErr", {31'b0, ackErr}, 32'd0);
    checkOutput("busyPulseBytesLeft", expQ.size(), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("busyPulseNoSecondFrame", {30'b0, busy, sclOe}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
